instr_encoder_loader: RTL and testbench

Sequential encoder and loader, the producing end of the instruction-word interface consumed by the decoder. Accepts field-level instruction descriptions over a valid/ready handshake. Checks each opcode/funct against the supported instruction set, packs it into a 32-bit MIPS word, and writes consecutive words into program memory. Used for boot-time and UART-driven program loading ahead of the core.

---
 rtl/instr_encoder_loader.sv | 155 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Field-level instruction encoder and program-memory loader.
// Accepts one bundle per handshake, legality-checks it, packs a MIPS word and writes it.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  input  logic                  last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   instr_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {IDLE, ACCEPT, ENCODE, WRITE, DONE, ERR} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t state, state_nxt;

  logic [1:0]  f_fmt;
  logic [5:0]  f_op, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm;
  logic [25:0] f_target;
  logic        f_last;

  logic        is_r_op, is_i_op, is_j_op, funct_ok;
  logic [1:0]  enc_err;
  logic [31:0] enc_word;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic        full;

  assign is_r_op  = (f_op == 6'h00);
  assign is_i_op  = f_op inside {6'h04, 6'h05, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  assign is_j_op  = f_op inside {6'h02, 6'h03};
  assign funct_ok = f_funct inside {6'h00, 6'h08, 6'h12, 6'h18, 6'h20, 6'h25, 6'h2A};

  // An opcode legal in some other format is a format mismatch (2); unknown everywhere is illegal (1).
  always_comb begin
    enc_err  = 2'd0;
    enc_word = 32'd0;
    case (f_fmt)
      2'd0: begin
        enc_word = {6'b0, f_rs, f_rt, f_rd, f_shamt, f_funct};
        if (!is_r_op)       enc_err = (is_i_op || is_j_op) ? 2'd2 : 2'd1;
        else if (!funct_ok) enc_err = 2'd1;
      end
      2'd1: begin
        enc_word = {f_op, f_rs, f_rt, f_imm};
        if (!is_i_op) enc_err = (is_r_op || is_j_op) ? 2'd2 : 2'd1;
      end
      2'd2: begin
        enc_word = {f_op, f_target};
        if (!is_j_op) enc_err = (is_r_op || is_i_op) ? 2'd2 : 2'd1;
      end
      default: enc_err = 2'd2;
    endcase
  end

  // Count can never exceed 2^ADDR_WIDTH, so the carry bit alone flags a full memory.
  assign cnt_inc = instr_count + 1'b1;
  assign full    = cnt_inc[ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = ACCEPT;
      ACCEPT:          if (in_valid) state_nxt = ENCODE;
      ENCODE:          state_nxt = (enc_err != 2'd0) ? ERR : WRITE;
      WRITE:           state_nxt = f_last ? DONE : (full ? ERR : ACCEPT);
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT);
    mem_we   = (state == WRITE);
    busy     = (state == ACCEPT) || (state == ENCODE) || (state == WRITE);
    done     = (state == DONE);
    error    = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr    <= BASE;
      mem_wdata   <= 32'd0;
      instr_count <= '0;
      err_code    <= 2'd0;
      f_fmt       <= 2'd0;
      f_op        <= 6'd0;
      f_funct     <= 6'd0;
      f_rs        <= 5'd0;
      f_rt        <= 5'd0;
      f_rd        <= 5'd0;
      f_shamt     <= 5'd0;
      f_imm       <= 16'd0;
      f_target    <= 26'd0;
      f_last      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          mem_addr    <= BASE;
          instr_count <= '0;
          err_code    <= 2'd0;
        end
        ACCEPT: if (in_valid) begin
          f_fmt    <= fmt;
          f_op     <= opcode;
          f_funct  <= funct;
          f_rs     <= rs;
          f_rt     <= rt;
          f_rd     <= rd;
          f_shamt  <= shamt;
          f_imm    <= imm;
          f_target <= target;
          f_last   <= last;
        end
        ENCODE: begin
          if (enc_err != 2'd0) err_code  <= enc_err;
          else                 mem_wdata <= enc_word;
        end
        WRITE: begin
          instr_count <= cnt_inc;
          mem_addr    <= mem_addr + 1'b1;
          if (!f_last && full) err_code <= 2'd3;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: default-size loader plus a 4-word instance for the memory-full path.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, start2, in_valid, last;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready, mem_we, busy, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  instr_count;
  logic [1:0]  err_code;

  logic        in_ready2, mem_we2, busy2, done2, error2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  instr_count2;
  logic [1:0]  err_code2;

  int checks = 0, errors = 0, cyc = 0;
  int nwr = 0, nwr2 = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          wr_cyc  [16];
  logic [31:0] wr2_addr[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .instr_count(instr_count), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .last(last), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .instr_count(instr_count2), .busy(busy2), .done(done2),
    .error(error2), .err_code(err_code2)
  );

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we && nwr < 16) begin
      wr_addr[nwr] <= 32'(mem_addr);
      wr_data[nwr] <= mem_wdata;
      wr_cyc[nwr]  <= cyc;
    end
    if (mem_we) nwr <= nwr + 1;
    if (mem_we2 && nwr2 < 16) wr2_addr[nwr2] <= 32'(mem_addr2);
    if (mem_we2) nwr2 <= nwr2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic send(input int sel, input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [4:0] sh, input logic [15:0] im, input logic [25:0] tg,
                      input logic lst);
    int n;
    @(negedge clk);
    fmt = f; opcode = op; funct = fn; rs = s; rt = t; rd = d; shamt = sh;
    imm = im; target = tg; last = lst; in_valid = 1'b1;
    n = 0;
    while (!(sel == 0 ? in_ready : in_ready2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(sel == 0 ? in_ready : in_ready2), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input int sel);
    int n;
    n = 0;
    while (!(sel == 0 ? (done || error) : (done2 || error2)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("end_reached", 32'(sel == 0 ? (done || error) : (done2 || error2)), 32'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; last = 1'b0;
    fmt = '0; opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    reset = 1'b1;

    // Single R add
    pulse_start(0);
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(in_ready), 1);
    send(0, 2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
    wait_end(0);
    chk("add_nwr", 32'(nwr), 1);
    chk("add_addr", wr_addr[0], 32'h0);
    chk("add_data", wr_data[0], 32'h00221820);
    chk("add_count", 32'(instr_count), 1);
    chk("add_done", 32'(done), 1);
    chk("add_busy", 32'(busy), 0);

    // addi / lw / j session
    nwr = 0;
    pulse_start(0);
    chk("restart_count", 32'(instr_count), 0);
    chk("restart_done", 32'(done), 0);
    send(0, 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
    send(0, 2'd1, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
    send(0, 2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
    wait_end(0);
    chk("seq_nwr", 32'(nwr), 3);
    chk("seq_d0", wr_data[0], 32'h20080005);
    chk("seq_d1", wr_data[1], 32'h8D090004);
    chk("seq_d2", wr_data[2], 32'h08000010);
    chk("seq_a1", wr_addr[1], 32'h1);
    chk("seq_a2", wr_addr[2], 32'h2);
    chk("seq_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 3);
    chk("seq_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 3);
    chk("seq_count", 32'(instr_count), 3);

    // sll then format mismatch
    nwr = 0;
    pulse_start(0);
    send(0, 2'd0, 6'h00, 6'h00, 5'd0, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
    send(0, 2'd0, 6'h08, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    wait_end(0);
    chk("sll_nwr", 32'(nwr), 1);
    chk("sll_data", wr_data[0], 32'h00011100);
    chk("mis_error", 32'(error), 1);
    chk("mis_code", 32'(err_code), 2);
    chk("mis_busy", 32'(busy), 0);

    // Illegal opcode, then restart clears error state
    nwr = 0;
    pulse_start(0);
    send(0, 2'd1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    wait_end(0);
    chk("ill_code", 32'(err_code), 1);
    chk("ill_nwr", 32'(nwr), 0);
    pulse_start(0);
    chk("clr_error", 32'(error), 0);
    chk("clr_code", 32'(err_code), 0);
    chk("clr_count", 32'(instr_count), 0);
    chk("clr_addr", 32'(mem_addr), 0);

    // Reset during WRITE drops the strobe
    fmt = 2'd0; opcode = 6'h00; funct = 6'h20; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; last = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wr_strobe", 32'(mem_we), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("ra_mem_we", 32'(mem_we), 0);
    chk("ra_busy", 32'(busy), 0);
    chk("ra_in_ready", 32'(in_ready), 0);
    chk("ra_wdata", mem_wdata, 0);
    chk("ra_count", 32'(instr_count), 0);
    chk("ra_addr", 32'(mem_addr), 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;

    // Memory full on the 4-word instance
    pulse_start(1);
    for (int i = 0; i < 4; i++)
      send(1, 2'd1, 6'h08, 6'h00, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'd0, 1'b0);
    in_valid = 1'b1;
    wait_end(1);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("full_code", 32'(err_code2), 3);
    chk("full_error", 32'(error2), 1);
    chk("full_count", 32'(instr_count2), 4);
    chk("full_nwr", 32'(nwr2), 4);
    for (int i = 0; i < 4; i++) chk("full_addr", wr2_addr[i], 32'(i));
    chk("full_other_idle", 32'(nwr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
